// File: rtl/cpu_pkg.sv
// Shared types and helpers for the cpu_core data-processing slice.
//   cond_e   : ARM condition field [31:28]
//   opcode_e : data-processing opcode [24:21]
//   shift_e  : shift type [6:5]
//   state_e  : execution FSM states
//   cond_pass: evaluates a condition against the NZCV flags
package cpu_pkg;

    localparam int REG_COUNT = 16;
    localparam int FLAG_N    = 3;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_C    = 1;
    localparam int FLAG_V    = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    // nzcv packed as {N,Z,C,V}
    function automatic logic cond_pass(input cond_e cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic pass;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/cpu_core_barrel_shifter.sv
// ARM-style barrel shifter (combinational).
//   value      in  32  operand to shift
//   amount     in  8   shift amount (0 = no shift, carry passes through)
//   shift_type in  2   LSL/LSR/ASR/ROR
//   rrx        in  1   rotate right by one through carry (overrides the rest)
//   cin        in  1   current carry flag
//   result     out 32  shifted value
//   cout       out 1   shifter carry-out
module barrel_shifter
    import cpu_pkg::*;
(
    input  logic [31:0] value,
    input  logic [7:0]  amount,
    input  logic [1:0]  shift_type,
    input  logic        rrx,
    input  logic        cin,
    output logic [31:0] result,
    output logic        cout
);

    logic [32:0] ext;
    logic [63:0] dbl;
    logic [5:0]  amt_clamped;

    // Every amount >= 32 behaves like 32 for ASR; LSL/LSR treat >32 separately.
    assign amt_clamped = (amount > 8'd32) ? 6'd32 : amount[5:0];

    always_comb begin
        result = value;
        cout   = cin;
        ext    = '0;
        dbl    = '0;
        if (rrx) begin
            result = {cin, value[31:1]};
            cout   = value[0];
        end else if (amount != 8'd0) begin
            case (shift_e'(shift_type))
                SHIFT_LSL: begin
                    // Extra bit on top catches the last bit shifted out.
                    if (amount > 8'd32) begin
                        result = '0;
                        cout   = 1'b0;
                    end else begin
                        ext    = {1'b0, value} << amt_clamped;
                        result = ext[31:0];
                        cout   = ext[32];
                    end
                end
                SHIFT_LSR: begin
                    if (amount > 8'd32) begin
                        result = '0;
                        cout   = 1'b0;
                    end else begin
                        ext    = {value, 1'b0} >> amt_clamped;
                        result = ext[32:1];
                        cout   = ext[0];
                    end
                end
                SHIFT_ASR: begin
                    ext    = $signed({value, 1'b0}) >>> amt_clamped;
                    result = ext[32:1];
                    cout   = ext[0];
                end
                default: begin
                    // Multiples of 32 leave the value intact, carry = bit 31.
                    dbl    = {value, value} >> amount[4:0];
                    result = dbl[31:0];
                    cout   = dbl[31];
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle ARM-style data-processing core. Each reset release runs the
// instruction on instr once (LOAD -> READ -> EXEC -> WRITE) and parks in WAIT.
//   clk          in  1   clock
//   rst_n        in  1   synchronous active-low reset; restarts at LOAD
//   instr        in  32  data-processing instruction, latched in LOAD
//   waiting      out 1   instruction complete, core idle
//   status_out   out 32  {N,Z,C,V,28'b0}
//   datapath_out out 32  ALU result of the last executed instruction
// Register file, flags and datapath_out are not cleared by reset; they hold
// their power-up value of zero until written.
module cpu_core
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic        waiting,
    output logic [31:0] status_out,
    output logic [31:0] datapath_out
);

    logic [31:0] reg_file [REG_COUNT] = '{default: 32'h0};
    logic [3:0]  nzcv_reg = 4'h0;
    logic [31:0] dp_reg   = 32'h0;

    state_e      state_reg;
    logic        waiting_reg;
    logic [31:0] instr_reg;
    logic [31:0] rn_reg;
    logic [31:0] rm_reg;
    logic [7:0]  rs_lo_reg;
    logic [31:0] alu_res_reg;
    logic [3:0]  flags_res_reg;
    logic        cond_ok_reg;
    logic        do_rd_reg;
    logic        do_flags_reg;
    logic        dp_load_reg;

    // Instruction fields
    cond_e       cond;
    opcode_e     opcode;
    logic        imm_op;
    logic        s_bit;
    logic        is_dp;
    logic        test_op;
    logic [3:0]  rd_idx;

    assign cond    = cond_e'(instr_reg[31:28]);
    assign opcode  = opcode_e'(instr_reg[24:21]);
    assign imm_op  = instr_reg[25];
    assign s_bit   = instr_reg[20];
    assign is_dp   = (instr_reg[27:26] == 2'b00);
    assign test_op = (instr_reg[24:23] == 2'b10);   // TST/TEQ/CMP/CMN
    assign rd_idx  = instr_reg[15:12];

    // Operand2 steering into the shared shifter
    logic [31:0] sh_value;
    logic [7:0]  sh_amount;
    logic [1:0]  sh_type;
    logic        sh_rrx;
    logic [31:0] op2;
    logic        sh_cout;

    always_comb begin
        sh_value  = rm_reg;
        sh_amount = 8'd0;
        sh_type   = instr_reg[6:5];
        sh_rrx    = 1'b0;
        if (imm_op) begin
            // Rotation by 0 keeps the carry, matching the shifter's amount==0 rule.
            sh_value  = {24'h0, instr_reg[7:0]};
            sh_amount = {3'b000, instr_reg[11:8], 1'b0};
            sh_type   = SHIFT_ROR;
        end else if (!instr_reg[4]) begin
            if (instr_reg[11:7] != 5'd0) begin
                sh_amount = {3'b000, instr_reg[11:7]};
            end else begin
                case (shift_e'(instr_reg[6:5]))
                    SHIFT_LSL: sh_amount = 8'd0;
                    SHIFT_ROR: sh_rrx    = 1'b1;
                    default:   sh_amount = 8'd32;
                endcase
            end
        end else begin
            sh_amount = rs_lo_reg;
        end
    end

    barrel_shifter u_shifter (
        .value      (sh_value),
        .amount     (sh_amount),
        .shift_type (sh_type),
        .rrx        (sh_rrx),
        .cin        (nzcv_reg[FLAG_C]),
        .result     (op2),
        .cout       (sh_cout)
    );

    // ALU
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        carry_in;
    logic        arith;
    logic [32:0] sum;
    logic [31:0] logic_res;
    logic [31:0] alu_res;
    logic [3:0]  alu_flags;

    always_comb begin
        op_a      = rn_reg;
        op_b      = op2;
        carry_in  = 1'b0;
        arith     = 1'b0;
        logic_res = '0;
        case (opcode)
            OP_AND, OP_TST: logic_res = rn_reg & op2;
            OP_EOR, OP_TEQ: logic_res = rn_reg ^ op2;
            OP_ORR:         logic_res = rn_reg | op2;
            OP_MOV:         logic_res = op2;
            OP_BIC:         logic_res = rn_reg & ~op2;
            OP_MVN:         logic_res = ~op2;
            // Subtraction as a + ~b + 1 so carry-out is "no borrow".
            OP_SUB, OP_CMP: begin arith = 1'b1; op_b = ~op2; carry_in = 1'b1; end
            OP_RSB:         begin arith = 1'b1; op_a = op2; op_b = ~rn_reg; carry_in = 1'b1; end
            OP_ADD, OP_CMN: begin arith = 1'b1; end
            OP_ADC:         begin arith = 1'b1; carry_in = nzcv_reg[FLAG_C]; end
            OP_SBC:         begin arith = 1'b1; op_b = ~op2; carry_in = nzcv_reg[FLAG_C]; end
            default:        begin arith = 1'b1; op_a = op2; op_b = ~rn_reg; carry_in = nzcv_reg[FLAG_C]; end
        endcase
        sum     = {1'b0, op_a} + {1'b0, op_b} + {32'h0, carry_in};
        alu_res = arith ? sum[31:0] : logic_res;
        alu_flags[FLAG_N] = alu_res[31];
        alu_flags[FLAG_Z] = (alu_res == 32'h0);
        alu_flags[FLAG_C] = arith ? sum[32] : sh_cout;
        alu_flags[FLAG_V] = arith ? ((op_a[31] == op_b[31]) && (sum[31] != op_a[31]))
                                  : nzcv_reg[FLAG_V];
    end

    // FSM and architectural state updates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_LOAD;
            waiting_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    instr_reg <= instr;
                    state_reg <= ST_READ;
                end
                ST_READ: begin
                    rn_reg    <= reg_file[instr_reg[19:16]];
                    rm_reg    <= reg_file[instr_reg[3:0]];
                    rs_lo_reg <= reg_file[instr_reg[11:8]][7:0];
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    alu_res_reg   <= alu_res;
                    flags_res_reg <= alu_flags;
                    cond_ok_reg   <= is_dp && cond_pass(cond, nzcv_reg);
                    do_rd_reg     <= !test_op;
                    do_flags_reg  <= test_op || s_bit;
                    dp_load_reg   <= is_dp;
                    state_reg     <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (dp_load_reg) begin
                        dp_reg <= alu_res_reg;
                    end
                    if (cond_ok_reg && do_flags_reg) begin
                        nzcv_reg <= flags_res_reg;
                    end
                    waiting_reg <= 1'b1;
                    state_reg   <= ST_WAIT;
                end
                default: begin
                    waiting_reg <= 1'b1;
                    state_reg   <= ST_WAIT;
                end
            endcase
        end
    end

    // Register file write port; a reset in WRITE suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && (state_reg == ST_WRITE) && cond_ok_reg && do_rd_reg) begin
            reg_file[rd_idx] <= alu_res_reg;
        end
    end

    assign waiting      = waiting_reg;
    assign status_out   = {nzcv_reg, 28'h0};
    assign datapath_out = dp_reg;

endmodule

// File: tb/tb_cpu_core.sv
module tb_cpu_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        waiting;
    logic [31:0] status_out;
    logic [31:0] datapath_out;

    cpu_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .waiting      (waiting),
        .status_out   (status_out),
        .datapath_out (datapath_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dp;
        logic [31:0] st;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic waiting_q = 1'b0;
    logic [31:0] cur_st = 32'h0;

    // Monitor: one completed instruction per rising edge of waiting.
    always @(negedge clk) begin
        if (waiting && !waiting_q) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_completion: datapath_out=%08h with no expected entry", datapath_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_cmp++;
                if (datapath_out !== e.dp) begin
                    n_bad++;
                    $display("FAIL %s datapath_out: got %08h expected %08h", e.name, datapath_out, e.dp);
                end
                n_cmp++;
                if (status_out !== e.st) begin
                    n_bad++;
                    $display("FAIL %s status_out: got %08h expected %08h", e.name, status_out, e.st);
                end
                $display("txn %-14s datapath_out=%08h status_out=%08h", e.name, datapath_out, status_out);
            end
        end
        waiting_q <= waiting;
    end

    task automatic check_waiting(input string name, input logic exp);
        n_cmp++;
        if (waiting !== exp) begin
            n_bad++;
            $display("FAIL %s waiting: got %b expected %b", name, waiting, exp);
        end
    endtask

    // Reset pulse, then four edges to completion. instr is scrambled after
    // LOAD so a core that re-samples it produces a wrong result.
    task automatic run(input string name, input logic [31:0] ins,
                       input logic [31:0] exp_dp, input logic [31:0] exp_st);
        exp_t e;
        e.dp = exp_dp;
        e.st = exp_st;
        e.name = name;
        sb_q.push_back(e);
        cur_st = exp_st;
        @(negedge clk);
        instr = ins;
        rst_n = 1'b0;
        @(negedge clk);
        check_waiting({name, "_reset"}, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instr = 32'hDEAD_BEEF;
            check_waiting({name, "_busy"}, 1'b0);
        end
        @(negedge clk);
        check_waiting({name, "_done"}, 1'b1);
        @(negedge clk);
    endtask

    task automatic preload();
        for (int n = 0; n < 16; n++) begin
            run($sformatf("mov_r%0d", n), 32'hE3A0_0000 | (n << 12) | (n + 1), n + 1, cur_st);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        instr = 32'h0;
        repeat (3) @(negedge clk);

        preload();
        run("add_r2",      32'hE080_2001, 32'd3,         32'h0000_0000);
        run("adds_r1_imm", 32'hE291_1008, 32'd10,        32'h0000_0000);
        run("mov_r1_2",    32'hE3A0_1002, 32'd2,         32'h0000_0000);
        run("subs_r3",     32'hE050_3001, 32'hFFFF_FFFF, 32'h8000_0000);
        run("addeq_fail",  32'h0085_5005, 32'd12,        32'h8000_0000);
        run("mov_r6_r5",   32'hE1A0_6005, 32'd6,         32'h8000_0000);
        run("add_lsl_imm", 32'hE080_7200, 32'd17,        32'h8000_0000);
        run("add_lsl_reg", 32'hE080_7210, 32'd9,         32'h8000_0000);
        run("cmp_r0_r0",   32'hE150_0000, 32'd0,         32'h6000_0000);
        run("movs_rrx",    32'hE1B0_B060, 32'h8000_0000, 32'hA000_0000);
        run("mov_imm_rot", 32'hE3A0_C4FF, 32'hFF00_0000, 32'hA000_0000);
        run("movs_lsr32",  32'hE1B0_D02C, 32'h0000_0000, 32'h6000_0000);
        run("mov_never",   32'hF3A0_00FF, 32'h0000_00FF, 32'h6000_0000);
        run("add_r0_r0",   32'hE080_7000, 32'd2,         32'h6000_0000);

        // Abort MOV R8,#0x55 with a reset right after READ.
        @(negedge clk);
        instr = 32'hE3A0_8055;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_waiting("abort_reset", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_waiting("abort_idle", 1'b0);

        run("mov_r9_4",    32'hE3A0_9004, 32'd4,         32'h6000_0000);
        run("mov_r10_r8",  32'hE1A0_A008, 32'd9,         32'h6000_0000);

        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
